// File: rtl/ahbl_splitter_n.sv
// ahbl_splitter_n: N-port AHB-Lite address decoder and response multiplexer.
//
// Sits between a single AHB-Lite master and NUM_SLAVES slaves. Each slave owns
// the addresses for which ((HADDR ^ base) & mask) == 0; the lowest matching
// index wins. Accesses that no slave owns are answered by a built-in default
// slave with the two-cycle ERROR response. The decode errors are counted, and
// the address of the most recent one is kept for software.
//
// Ports:
//   HCLK, HRESETn   bus clock, asynchronous active-low reset
//   HADDR, HTRANS   master address phase
//   HREADY, HRESP   muxed ready/response (HREADY also fans out to slaves)
//   HRDATA          muxed read data
//   S_HSEL          per-slave address-phase select (HADDR decode only)
//   S_HRDATA        slave read data, slave i at [32i+31:32i]
//   S_HREADYOUT     per-slave ready
//   S_HRESP         per-slave response
//   ERR_CLR         synchronous clear of ERR_CNT
//   ERR_CNT         saturating decode-error count
//   ERR_ADDR        HADDR of the most recent decode error
module ahbl_splitter_n #(
  parameter int unsigned                NUM_SLAVES    = 5,
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_BASE    = {32'h6000_0000, 32'h8000_0000,
                                                         32'h4000_0000, 32'h2000_0000,
                                                         32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_MASK    = {NUM_SLAVES{32'hF000_0000}},
  parameter logic [31:0]                DEFAULT_RDATA = 32'hBADD_BEEF
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  output logic                       HREADY,
  output logic                       HRESP,
  output logic [31:0]                HRDATA,
  output logic [NUM_SLAVES-1:0]      S_HSEL,
  input  logic [32*NUM_SLAVES-1:0]   S_HRDATA,
  input  logic [NUM_SLAVES-1:0]      S_HREADYOUT,
  input  logic [NUM_SLAVES-1:0]      S_HRESP,
  input  logic                       ERR_CLR,
  output logic [7:0]                 ERR_CNT,
  output logic [31:0]                ERR_ADDR
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StErr1 = 2'd1;
  localparam logic [1:0] StErr2 = 2'd2;

  logic [NUM_SLAVES-1:0] match;
  logic [NUM_SLAVES-1:0] hsel;
  logic                  found;
  logic                  unmapped;
  logic                  err_entry;

  logic [NUM_SLAVES-1:0] sel_d, sel_q;
  logic [1:0]            state_d, state_q;
  logic [7:0]            err_cnt_d, err_cnt_q;
  logic [31:0]           err_addr_d, err_addr_q;

  // HTRANS[0] (SEQ vs NONSEQ) does not affect decoding.
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  // Address decode with lowest-index priority.
  always_comb begin
    match = '0;
    hsel  = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      match[i] = ((HADDR ^ SLAVE_BASE[32*i +: 32]) & SLAVE_MASK[32*i +: 32]) == 32'h0;
      if (match[i] && !found) begin
        hsel[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign S_HSEL   = hsel;
  assign unmapped = HTRANS[1] & ~|match;

  // ERR2 always has HREADY=1, so a new unmapped address phase there is
  // accepted and restarts the error response.
  assign err_entry = ((state_q == StIdle) && HREADY && unmapped) ||
                     ((state_q == StErr2) && unmapped);

  // Response multiplexer. sel_q is zero in ERR1/ERR2 because the unmapped
  // access that started the error loaded zero.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = DEFAULT_RDATA;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (sel_q[i]) begin
        HREADY = S_HREADYOUT[i];
        HRESP  = S_HRESP[i];
        HRDATA = S_HRDATA[32*i +: 32];
      end
    end
    case (state_q)
      StErr1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      StErr2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    sel_d      = sel_q;
    state_d    = state_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;

    if (HREADY) begin
      sel_d = hsel & {NUM_SLAVES{HTRANS[1]}};
    end

    case (state_q)
      StIdle:  if (err_entry) state_d = StErr1;
      StErr1:  state_d = StErr2;
      StErr2:  state_d = unmapped ? StErr1 : StIdle;
      default: state_d = StIdle;
    endcase

    // Clear wins, but an error entering in the same cycle still counts.
    if (ERR_CLR) begin
      err_cnt_d = err_entry ? 8'd1 : 8'd0;
    end else if (err_entry && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    if (err_entry) begin
      err_addr_d = HADDR;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q      <= '0;
      state_q    <= StIdle;
      err_cnt_q  <= 8'd0;
      err_addr_q <= 32'h0;
    end else begin
      sel_q      <= sel_d;
      state_q    <= state_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign ERR_CNT  = err_cnt_q;
  assign ERR_ADDR = err_addr_q;

endmodule
